// File: rtl/mw_wb_sched.sv
// Writeback scheduler: sequences one retiring instruction's memory beats,
// register-file writes and commit pulse over single shared write ports.
module mw_wb_sched (
    input  logic        clk,
    input  logic        clr,
    input  logic        in_v,
    output logic        in_rdy,
    input  logic        in_rf1_we,
    input  logic [2:0]  in_rf1_id,
    input  logic [31:0] in_rf1_data,
    input  logic        in_rf2_we,
    input  logic [2:0]  in_rf2_id,
    input  logic [31:0] in_rf2_data,
    input  logic        in_mwe,
    input  logic [31:0] in_maddr,
    input  logic [31:0] in_mdata,
    input  logic [1:0]  in_msize,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        rf_we,
    output logic [2:0]  rf_id,
    output logic [31:0] rf_data,
    output logic        commit
);

    typedef enum logic [2:0] {StIdle, StMemLo, StMemHi, StRf1, StRf2, StCmt} state_e;

    state_e      state_q, state_d;
    logic        rf1_we_q, rf2_we_q, mwe_q;
    logic [2:0]  rf1_id_q, rf2_id_q;
    logic [31:0] rf1_data_q, rf2_data_q, maddr_q, mdata_q;
    logic [1:0]  msize_q;

    logic [3:0]  mask;
    logic [1:0]  off;
    logic [7:0]  be_wide;
    logic [63:0] data_wide;
    logic        split;
    state_e      post_mem;

    // Lane alignment: the 8-bit/64-bit shifted views hold both beats, low half
    // is the first word, high half spills into the next word.
    always_comb begin
        off = maddr_q[1:0];
        unique case (msize_q)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        be_wide   = {4'b0000, mask} << off;
        data_wide = {32'd0, mdata_q} << {off, 3'b000};
        split     = |be_wide[7:4];
        post_mem  = rf1_we_q ? StRf1 : (rf2_we_q ? StRf2 : StCmt);
    end

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // Capture the whole instruction on accept; outputs only use these copies.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rf1_we_q   <= 1'b0;
            rf1_id_q   <= 3'd0;
            rf1_data_q <= 32'd0;
            rf2_we_q   <= 1'b0;
            rf2_id_q   <= 3'd0;
            rf2_data_q <= 32'd0;
            mwe_q      <= 1'b0;
            maddr_q    <= 32'd0;
            mdata_q    <= 32'd0;
            msize_q    <= 2'd0;
        end else if (in_v && in_rdy) begin
            rf1_we_q   <= in_rf1_we;
            rf1_id_q   <= in_rf1_id;
            rf1_data_q <= in_rf1_data;
            rf2_we_q   <= in_rf2_we;
            rf2_id_q   <= in_rf2_id;
            rf2_data_q <= in_rf2_data;
            mwe_q      <= in_mwe;
            maddr_q    <= in_maddr;
            mdata_q    <= in_mdata;
            msize_q    <= in_msize;
        end
    end

    // Next-state and per-state port drive; idle ports are held at zero.
    always_comb begin
        state_d  = state_q;
        in_rdy   = 1'b0;
        mem_req  = 1'b0;
        mem_addr = 32'd0;
        mem_data = 32'd0;
        mem_be   = 4'd0;
        rf_we    = 1'b0;
        rf_id    = 3'd0;
        rf_data  = 32'd0;
        commit   = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_rdy = 1'b1;
                if (in_v) begin
                    if (in_mwe)         state_d = StMemLo;
                    else if (in_rf1_we) state_d = StRf1;
                    else if (in_rf2_we) state_d = StRf2;
                    else                state_d = StCmt;
                end
            end
            StMemLo: begin
                mem_req  = 1'b1;
                mem_addr = {maddr_q[31:2], 2'b00};
                mem_be   = be_wide[3:0];
                mem_data = data_wide[31:0];
                if (mem_ack) state_d = split ? StMemHi : post_mem;
            end
            StMemHi: begin
                mem_req  = 1'b1;
                mem_addr = {maddr_q[31:2] + 30'd1, 2'b00};
                mem_be   = be_wide[7:4];
                mem_data = data_wide[63:32];
                if (mem_ack) state_d = post_mem;
            end
            StRf1: begin
                rf_we   = 1'b1;
                rf_id   = rf1_id_q;
                rf_data = rf1_data_q;
                state_d = rf2_we_q ? StRf2 : StCmt;
            end
            StRf2: begin
                rf_we   = 1'b1;
                rf_id   = rf2_id_q;
                rf_data = rf2_data_q;
                state_d = StCmt;
            end
            StCmt: begin
                commit  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // mwe_q is implied by the state path; kept for completeness of the capture.
    logic unused_mwe;
    assign unused_mwe = mwe_q;

endmodule

// File: tb/tb_mw_wb_sched.sv
// Scoreboard bench for mw_wb_sched: directed ops push expected events, a
// monitor pops and compares as the DUT presents beats, writes and commits.
module tb_mw_wb_sched;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        in_v = 1'b0;
    logic        in_rdy;
    logic        in_rf1_we = 1'b0;
    logic [2:0]  in_rf1_id = 3'd0;
    logic [31:0] in_rf1_data = 32'd0;
    logic        in_rf2_we = 1'b0;
    logic [2:0]  in_rf2_id = 3'd0;
    logic [31:0] in_rf2_data = 32'd0;
    logic        in_mwe = 1'b0;
    logic [31:0] in_maddr = 32'd0;
    logic [31:0] in_mdata = 32'd0;
    logic [1:0]  in_msize = 2'd0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic        rf_we;
    logic [2:0]  rf_id;
    logic [31:0] rf_data;
    logic        commit;

    mw_wb_sched dut (
        .clk(clk), .clr(clr), .in_v(in_v), .in_rdy(in_rdy),
        .in_rf1_we(in_rf1_we), .in_rf1_id(in_rf1_id), .in_rf1_data(in_rf1_data),
        .in_rf2_we(in_rf2_we), .in_rf2_id(in_rf2_id), .in_rf2_data(in_rf2_data),
        .in_mwe(in_mwe), .in_maddr(in_maddr), .in_mdata(in_mdata), .in_msize(in_msize),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_be(mem_be),
        .mem_ack(mem_ack), .rf_we(rf_we), .rf_id(rf_id), .rf_data(rf_data),
        .commit(commit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rf1_we;
        logic [2:0]  rf1_id;
        logic [31:0] rf1_data;
        logic        rf2_we;
        logic [2:0]  rf2_id;
        logic [31:0] rf2_data;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mdata;
        logic [1:0]  msize;
    } op_t;

    // kind: 0 memory beat, 1 register write (addr holds id), 2 commit
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  ack_wait = 0;
    bit  ack_idle = 1'b0;
    int  wcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_unexp(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got an unexpected event, expected queue size %0d (cycle %0d)",
                 name, q.size(), cyc);
    endtask

    task automatic push_ev(input int kind, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] d, input int c);
        ev_t e;
        e.kind = kind; e.addr = a; e.be = be; e.data = d; e.cyc = c;
        q.push_back(e);
    endtask

    // Memory model: acknowledge each beat after ack_wait stall cycles.
    always @(posedge clk) begin
        #1;
        if (!mem_req) begin
            wcnt = 0;
            mem_ack = ack_idle;
        end else if (wcnt >= ack_wait) begin
            mem_ack = 1'b1;
            wcnt = 0;
        end else begin
            mem_ack = 1'b0;
            wcnt++;
        end
    end

    // Monitor: compare presented outputs against the head of the queue.
    always @(negedge clk) begin
        if (clr) begin
            chk("rdy_vs_busy", {31'd0, in_rdy}, {31'd0, !(mem_req | rf_we | commit)});
            if (mem_req) begin
                if (q.size() == 0 || q[0].kind != 0) fail_unexp("unexpected_mem");
                else begin
                    chk("mem_addr", mem_addr, q[0].addr);
                    chk("mem_be", {28'd0, mem_be}, {28'd0, q[0].be});
                    chk("mem_data", mem_data, q[0].data);
                    if (mem_ack) begin
                        chk("mem_cycle", cyc, q[0].cyc);
                        void'(q.pop_front());
                    end
                end
            end else begin
                chk("mem_idle_zero", mem_addr | mem_data | {28'd0, mem_be}, 32'd0);
            end
            if (rf_we) begin
                if (q.size() == 0 || q[0].kind != 1) fail_unexp("unexpected_rf");
                else begin
                    chk("rf_id", {29'd0, rf_id}, q[0].addr);
                    chk("rf_data", rf_data, q[0].data);
                    chk("rf_cycle", cyc, q[0].cyc);
                    void'(q.pop_front());
                end
            end else begin
                chk("rf_idle_zero", rf_data | {29'd0, rf_id}, 32'd0);
            end
            if (commit) begin
                if (q.size() == 0 || q[0].kind != 2) fail_unexp("unexpected_commit");
                else begin
                    chk("commit_cycle", cyc, q[0].cyc);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_rdy"}, {31'd0, in_rdy}, 32'd1);
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_data"}, mem_data, 32'd0);
        chk({tag, "_mem_be"}, {28'd0, mem_be}, 32'd0);
        chk({tag, "_rf_we"}, {31'd0, rf_we}, 32'd0);
        chk({tag, "_rf_id"}, {29'd0, rf_id}, 32'd0);
        chk({tag, "_rf_data"}, rf_data, 32'd0);
        chk({tag, "_commit"}, {31'd0, commit}, 32'd0);
    endtask

    // Present an op once in_rdy is seen; acc is the cycle count of the first
    // action cycle after the accepting edge.
    task automatic issue(input op_t op, input bit keep, output int acc);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready", {31'd0, in_rdy}, 32'd1);
        in_rf1_we = op.rf1_we; in_rf1_id = op.rf1_id; in_rf1_data = op.rf1_data;
        in_rf2_we = op.rf2_we; in_rf2_id = op.rf2_id; in_rf2_data = op.rf2_data;
        in_mwe = op.mwe; in_maddr = op.maddr; in_mdata = op.mdata; in_msize = op.msize;
        in_v = 1'b1;
        acc = cyc + 1;
        @(posedge clk);
        #1;
        if (!keep) in_v = 1'b0;
    endtask

    // Wait until every expected event is seen and the scheduler is idle again.
    task automatic wait_drain(input string name, output int done);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!(q.size() == 0 && in_rdy) && n < 200);
        done = cyc;
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d pending events, expected 0", name, q.size());
            q.delete();
        end
    endtask

    function automatic op_t mk_op(input logic r1we, input logic [2:0] r1id,
                                  input logic [31:0] r1d, input logic r2we,
                                  input logic [2:0] r2id, input logic [31:0] r2d,
                                  input logic mwe, input logic [31:0] a,
                                  input logic [31:0] d, input logic [1:0] sz);
        op_t o;
        o.rf1_we = r1we; o.rf1_id = r1id; o.rf1_data = r1d;
        o.rf2_we = r2we; o.rf2_id = r2id; o.rf2_data = r2d;
        o.mwe = mwe; o.maddr = a; o.mdata = d; o.msize = sz;
        return o;
    endfunction

    initial begin
        op_t op;
        int  acc, acc2, done;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        clr = 1'b1;

        // Register-only op; stray mem_ack while idle must be ignored.
        ack_idle = 1'b1;
        op = mk_op(1, 3'd3, 32'h12345678, 0, 3'd0, 32'd0, 0, 32'd0, 32'd0, 2'd0);
        issue(op, 0, acc);
        push_ev(1, 32'd3, 4'd0, 32'h12345678, acc);
        push_ev(2, 32'd0, 4'd0, 32'd0, acc + 1);
        wait_drain("regonly", done);
        chk("regonly_rdy_cycle", done, acc + 2);
        ack_idle = 1'b0;

        // Aligned word store, zero-wait memory.
        ack_wait = 0;
        op = mk_op(0, 3'd0, 32'd0, 0, 3'd0, 32'd0, 1, 32'h00001000, 32'hAABBCCDD, 2'd2);
        issue(op, 0, acc);
        push_ev(0, 32'h00001000, 4'b1111, 32'hAABBCCDD, acc);
        push_ev(2, 32'd0, 4'd0, 32'd0, acc + 1);
        wait_drain("aligned", done);
        chk("aligned_rdy_cycle", done, acc + 2);

        // Split halfword store with two stall cycles per beat.
        ack_wait = 2;
        op = mk_op(0, 3'd0, 32'd0, 0, 3'd0, 32'd0, 1, 32'h00002003, 32'h0000BEEF, 2'd1);
        issue(op, 0, acc);
        push_ev(0, 32'h00002000, 4'b1000, 32'hEF000000, acc + 2);
        push_ev(0, 32'h00002004, 4'b0001, 32'h000000BE, acc + 5);
        push_ev(2, 32'd0, 4'd0, 32'd0, acc + 6);
        wait_drain("split", done);

        // Word store across the top of the address space.
        ack_wait = 0;
        op = mk_op(0, 3'd0, 32'd0, 0, 3'd0, 32'd0, 1, 32'hFFFFFFFE, 32'h11223344, 2'd2);
        issue(op, 0, acc);
        push_ev(0, 32'hFFFFFFFC, 4'b1100, 32'h33440000, acc);
        push_ev(0, 32'h00000000, 4'b0011, 32'h00001122, acc + 1);
        push_ev(2, 32'd0, 4'd0, 32'd0, acc + 2);
        wait_drain("wrap", done);

        // Size code 3 behaves as a word; byte store at offset 1.
        op = mk_op(0, 3'd0, 32'd0, 0, 3'd0, 32'd0, 1, 32'h00005001, 32'h000000A5, 2'd0);
        issue(op, 0, acc);
        push_ev(0, 32'h00005000, 4'b0010, 32'h0000A500, acc);
        push_ev(2, 32'd0, 4'd0, 32'd0, acc + 1);
        wait_drain("byte", done);
        op = mk_op(0, 3'd0, 32'd0, 0, 3'd0, 32'd0, 1, 32'h00006000, 32'h01020304, 2'd3);
        issue(op, 0, acc);
        push_ev(0, 32'h00006000, 4'b1111, 32'h01020304, acc);
        push_ev(2, 32'd0, 4'd0, 32'd0, acc + 1);
        wait_drain("size3", done);

        // PUSH-like op with in_v held high: second accept only after in_rdy.
        op = mk_op(1, 3'd4, 32'h00000100, 1, 3'd4, 32'h000000FC, 1, 32'h00003000,
                   32'hCAFEF00D, 2'd2);
        issue(op, 1, acc);
        push_ev(0, 32'h00003000, 4'b1111, 32'hCAFEF00D, acc);
        push_ev(1, 32'd4, 4'd0, 32'h00000100, acc + 1);
        push_ev(1, 32'd4, 4'd0, 32'h000000FC, acc + 2);
        push_ev(2, 32'd0, 4'd0, 32'd0, acc + 3);
        issue(op, 0, acc2);
        chk("push_issue_gap", acc2, acc + 5);
        push_ev(0, 32'h00003000, 4'b1111, 32'hCAFEF00D, acc2);
        push_ev(1, 32'd4, 4'd0, 32'h00000100, acc2 + 1);
        push_ev(1, 32'd4, 4'd0, 32'h000000FC, acc2 + 2);
        push_ev(2, 32'd0, 4'd0, 32'd0, acc2 + 3);
        wait_drain("push", done);

        // No-write ops back to back: two-cycle issue interval.
        op = mk_op(0, 3'd0, 32'd0, 0, 3'd0, 32'd0, 0, 32'd0, 32'd0, 2'd0);
        issue(op, 1, acc);
        push_ev(2, 32'd0, 4'd0, 32'd0, acc);
        issue(op, 0, acc2);
        chk("nowrite_issue_gap", acc2, acc + 2);
        push_ev(2, 32'd0, 4'd0, 32'd0, acc2);
        wait_drain("nowrite", done);
        chk("nowrite_rdy_cycle", done, acc2 + 1);

        // Reset while the second beat is stalled.
        ack_wait = 3;
        op = mk_op(1, 3'd1, 32'h55555555, 0, 3'd0, 32'd0, 1, 32'h00004001, 32'hDEADBEEF, 2'd2);
        issue(op, 0, acc);
        push_ev(0, 32'h00004000, 4'b1110, 32'hADBEEF00, acc + 3);
        push_ev(0, 32'h00004004, 4'b0001, 32'h000000DE, acc + 7);
        while (cyc < acc + 5) @(negedge clk);
        #3;
        clr = 1'b0;
        q.delete();
        #1;
        chk_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        clr = 1'b1;
        repeat (8) @(negedge clk);
        #2;
        chk("post_reset_rdy", {31'd0, in_rdy}, 32'd1);

        ack_wait = 1;
        op = mk_op(0, 3'd0, 32'd0, 1, 3'd7, 32'h0BADCAFE, 1, 32'h00007002, 32'h0000ABCD, 2'd1);
        issue(op, 0, acc);
        push_ev(0, 32'h00007000, 4'b1100, 32'hABCD0000, acc + 1);
        push_ev(1, 32'd7, 4'd0, 32'h0BADCAFE, acc + 2);
        push_ev(2, 32'd0, 4'd0, 32'd0, acc + 3);
        wait_drain("after_reset", done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
